dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data RAM between two requesters:
//   - the pipeline MEM stage (core)
//   - the debug/loader port (dbg)
//  Issues at most one RAM access per cycle and routes read data back to the requester that issued it.
//  Raises core_stall so the hazard logic can freeze the pipeline while the core is denied.
//  Sits between the EX/MEM register outputs and the data RAM.
// PARAMETERS
//  ADDR_W      32  address width, core and dbg
//  STARVE_MAX  4   consecutive denied dbg cycles before dbg is forced ahead of core (>=1)
//  CNT_W       16  width of the conflict_cnt statistic
// PORTS
//  clk          in   1       main (debug-stepped) clock, rising edge
//  rst          in   1       reset, asynchronous, active-low
//  core_req     in   1       core access request; held until accepted
//  core_we      in   1       1 = store, 0 = load
//  core_addr    in   ADDR_W  byte address
//  core_wdata   in   32      store data
//  core_ubhw    in   3       funct3 width/sign code, passed to RAM
//  core_stall   out  1       core_req & ~core_gnt (combinational)
//  core_rvalid  out  1       core read data valid this cycle
//  core_rdata   out  32      read data; equals ram_rdata when core_rvalid
//  dbg_req      in   1       debug access request; held until dbg_gnt
//  dbg_we       in   1       1 = write, 0 = read
//  dbg_addr     in   ADDR_W  byte address
//  dbg_wdata    in   32      write data
//  dbg_ubhw     in   3       width/sign code
//  dbg_gnt      out  1       debug request accepted this cycle (combinational)
//  dbg_rvalid   out  1       debug read data valid this cycle
//  dbg_rdata    out  32      read data; equals ram_rdata when dbg_rvalid
//  ram_addr     out  ADDR_W  to RAM: address of the selected requester
//  ram_we       out  1       to RAM: write enable; 0 when nothing is granted
//  ram_wdata    out  32      to RAM: write data
//  ram_ubhw     out  3       to RAM: width/sign code
//  ram_rdata    in   32      from RAM: valid the cycle after a read is issued
//  conflict_cnt out  CNT_W   saturating count of cycles the core was stalled by dbg
// BEHAVIOUR
//  Grant (combinational, evaluated every cycle):
//   - force_dbg = dbg_req & (starve_cnt == STARVE_MAX).
//   - If force_dbg: grant dbg, even if core_req is high.
//   - Else if core_req: grant core.
//   - Else if dbg_req: grant dbg.
//   - Else: no grant.
//   - The granted requester's addr/wdata/ubhw/we drive ram_*.
//   - With no grant: ram_we = 0; ram_addr/ram_wdata/ram_ubhw hold the core values (don't-care).
//  Accept: an access completes its request phase at the rising edge of its grant cycle.
//   - Requester may change or drop req in the next cycle.
//   - Back-to-back accepts, one per cycle, are legal.
//  Read return: 1-cycle latency.
//   - Registered rd_owner in {NONE, CORE, DBG} is set at the edge when a read (we=0) is granted.
//   - rd_owner is NONE after a write or an idle cycle.
//   - Next cycle: core_rvalid = (rd_owner==CORE); dbg_rvalid = (rd_owner==DBG).
//   - Return of a previous read and issue of a new access in the same cycle is legal and required at full rate.
//   - core_rdata and dbg_rdata wire directly to ram_rdata.
//  Starvation counter starve_cnt, width clog2(STARVE_MAX+1):
//   - +1 per cycle when dbg_req=1 and dbg not granted.
//   - Cleared when dbg is granted or dbg_req=0.
//   - Never exceeds STARVE_MAX.
//   - Net effect: with continuous core traffic, dbg is served every STARVE_MAX+1 cycles.
//  conflict_cnt:
//   - +1 per cycle when core_req=1 and dbg granted.
//   - Saturates at all-ones; no wrap.
//  Reset (rst=0, async):
//   - rd_owner=NONE, starve_cnt=0, conflict_cnt=0.
//   - core_rvalid=0, dbg_rvalid=0.
//   - Grants forced 0 while rst=0: core_stall = core_req, dbg_gnt=0, ram_we=0.
//   - A read outstanding at reset assertion is dropped; no rvalid is produced after release.
//   - First grant possible in the first cycle after rst deasserts.
//  Same-address conflicts: none possible (single issue per cycle). Ordering is grant order.
// TESTING
//  1 Reset: rst=0 with core_req=1, dbg_req=1 -> core_stall=1, dbg_gnt=0, ram_we=0, rvalids=0, conflict_cnt=0.
//  2 Core only: load addr 0x10 (RAM holds 0xDEADBEEF) -> core_stall=0, ram_addr=0x10, ram_we=0;
//    next cycle core_rvalid=1, core_rdata=0xDEADBEEF, dbg_rvalid=0.
//  3 Starvation: core_req=1 continuous and dbg_req=1 continuous from cycle 0, STARVE_MAX=4 ->
//    dbg_gnt at cycles 4, 9, 14; core_stall=1 exactly those cycles; conflict_cnt=3 at cycle 15.
//  4 Idle-core dbg: dbg write 0x12345678 to 0x40, then dbg read 0x40 back-to-back ->
//    dbg_gnt both cycles; ram_we 1 then 0; dbg_rvalid=1 with 0x12345678 in the third cycle.
//  5 Interleaved return: core read 0x20, then dbg read 0x24 next cycle (core_req low) ->
//    core_rvalid in cycle 2 concurrent with dbg issue; dbg_rvalid in cycle 3; each with its own data.
//  6 Reset mid-read: core read granted, rst=0 before next edge -> no core_rvalid after release;
//    starve_cnt and conflict_cnt both 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the pipeline MEM
// stage (core) and the debug/loader port (dbg). One RAM access is issued per
// cycle. Read data comes back one cycle later and is flagged valid only to the
// requester that issued the read. The core normally wins. A debug requester
// that has been denied STARVE_MAX cycles in a row is forced ahead once.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low

  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [2:0]        core_ubhw,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [31:0]       core_rdata,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  input  logic [2:0]        dbg_ubhw,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,

  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  output logic [2:0]        ram_ubhw,
  input  logic [31:0]       ram_rdata,

  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int                  STARVE_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0]    CNT_SAT    = '1;

  // Which requester (if any) owns the read data arriving next cycle.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_CORE = 2'd1,
    RD_DBG  = 2'd2
  } rd_owner_t;

  rd_owner_t           rd_owner_reg, rd_owner_next;
  logic [STARVE_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic [CNT_W-1:0]    conflict_cnt_reg, conflict_cnt_next;

  logic force_dbg;
  logic core_gnt;
  logic dbg_gnt_int;

  // Grant selection: a starved dbg first, then core, then dbg. Nothing is
  // granted while reset is held, so no RAM write can slip through.
  always_comb begin
    force_dbg   = dbg_req & (starve_cnt_reg == STARVE_LIM);
    core_gnt    = 1'b0;
    dbg_gnt_int = 1'b0;
    if (rst) begin
      if (force_dbg) begin
        dbg_gnt_int = 1'b1;
      end else if (core_req) begin
        core_gnt = 1'b1;
      end else if (dbg_req) begin
        dbg_gnt_int = 1'b1;
      end
    end
  end

  // RAM request mux. The core fields are the idle default, and only the
  // write enable has to be qualified by a grant.
  always_comb begin
    ram_addr  = core_addr;
    ram_wdata = core_wdata;
    ram_ubhw  = core_ubhw;
    ram_we    = core_gnt & core_we;
    if (dbg_gnt_int) begin
      ram_addr  = dbg_addr;
      ram_wdata = dbg_wdata;
      ram_ubhw  = dbg_ubhw;
      ram_we    = dbg_we;
    end
  end

  // Read-owner next state: a granted load claims the next cycle's RAM data.
  // Writes and idle cycles leave no owner.
  always_comb begin
    rd_owner_next = RD_NONE;
    if (core_gnt && !core_we) begin
      rd_owner_next = RD_CORE;
    end else if (dbg_gnt_int && !dbg_we) begin
      rd_owner_next = RD_DBG;
    end
  end

  // Starvation and conflict statistics next state.
  always_comb begin
    starve_cnt_next = '0;
    if (dbg_req && !dbg_gnt_int && (starve_cnt_reg != STARVE_LIM)) begin
      starve_cnt_next = starve_cnt_reg + STARVE_W'(1);
    end else if (dbg_req && !dbg_gnt_int) begin
      starve_cnt_next = starve_cnt_reg;
    end

    conflict_cnt_next = conflict_cnt_reg;
    if (core_req && dbg_gnt_int && (conflict_cnt_reg != CNT_SAT)) begin
      conflict_cnt_next = conflict_cnt_reg + CNT_W'(1);
    end
  end

  // Read-owner state register. Reset drops any read that is still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_owner_reg <= RD_NONE;
    end else begin
      rd_owner_reg <= rd_owner_next;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_reg   <= '0;
      conflict_cnt_reg <= '0;
    end else begin
      starve_cnt_reg   <= starve_cnt_next;
      conflict_cnt_reg <= conflict_cnt_next;
    end
  end

  assign core_stall   = core_req & ~core_gnt;
  assign dbg_gnt      = dbg_gnt_int;
  assign core_rvalid  = (rd_owner_reg == RD_CORE);
  assign dbg_rvalid   = (rd_owner_reg == RD_DBG);
  assign core_rdata   = ram_rdata;
  assign dbg_rdata    = ram_rdata;
  assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors for dmem_arbiter, with a small
// synchronous RAM model behind the arbiter.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [2:0]  core_ubhw;
  logic        core_stall, core_rvalid;
  logic [31:0] core_rdata;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic [2:0]  dbg_ubhw;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we;
  logic [2:0]  ram_ubhw;
  logic [15:0] conflict_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .STARVE_MAX(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ubhw(core_ubhw), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ubhw(dbg_ubhw), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_ubhw(ram_ubhw), .ram_rdata(ram_rdata),
    .conflict_cnt(conflict_cnt)
  );

  // RAM model: word-addressed, one-cycle read latency, preset contents for
  // words that have not been written yet.
  bit   [31:0] mem [256];
  bit          wr_flag [256];
  logic [7:0]  ridx;
  assign ridx = ram_addr[9:2];

  function automatic logic [31:0] preset(input logic [7:0] idx);
    case (idx)
      8'h04:   return 32'hDEADBEEF;  // byte 0x10
      8'h08:   return 32'hA5A50020;  // byte 0x20
      8'h09:   return 32'h5A5A0024;  // byte 0x24
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ridx]     <= ram_wdata;
      wr_flag[ridx] <= 1'b1;
    end
    ram_rdata <= wr_flag[ridx] ? mem[ridx] : preset(ridx);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  // Inputs change 1 time unit after the rising edge. Checks are made 3 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0; core_ubhw = 3'b010;
    dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_addr  = 32'h0; dbg_wdata  = 32'h0; dbg_ubhw  = 3'b010;

    // 1: reset with both requests high
    #3;
    check("rst core_stall", 32'(core_stall), 32'd1);
    check("rst dbg_gnt", 32'(dbg_gnt), 32'd0);
    check("rst ram_we", 32'(ram_we), 32'd0);
    check("rst core_rvalid", 32'(core_rvalid), 32'd0);
    check("rst dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    check("rst conflict_cnt", 32'(conflict_cnt), 32'd0);
    tick();
    #3;
    check("rst+1 core_stall", 32'(core_stall), 32'd1);
    check("rst+1 ram_we", 32'(ram_we), 32'd0);
    check("rst+1 conflict_cnt", 32'(conflict_cnt), 32'd0);

    // 2: core load from 0x10 in the first cycle after release
    tick();
    rst = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
    dbg_req = 1'b0;
    #3;
    check("ld core_stall", 32'(core_stall), 32'd0);
    check("ld ram_addr", ram_addr, 32'h10);
    check("ld ram_we", 32'(ram_we), 32'd0);
    check("ld core_rvalid early", 32'(core_rvalid), 32'd0);
    tick();
    core_req = 1'b0;
    #3;
    check("ld core_rvalid", 32'(core_rvalid), 32'd1);
    check("ld core_rdata", core_rdata, 32'hDEADBEEF);
    check("ld dbg_rvalid", 32'(dbg_rvalid), 32'd0);

    // 3: continuous core and dbg writes; dbg forced at cycles 4, 9, 14
    tick();
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h80; core_wdata = 32'h1111;
    dbg_req  = 1'b1; dbg_we  = 1'b1; dbg_addr  = 32'h84; dbg_wdata  = 32'h2222;
    for (int c = 0; c < 16; c++) begin
      logic exp_d;
      exp_d = (c == 4) || (c == 9) || (c == 14);
      #3;
      check($sformatf("starve c%0d dbg_gnt", c), 32'(dbg_gnt), 32'(exp_d));
      check($sformatf("starve c%0d core_stall", c), 32'(core_stall), 32'(exp_d));
      check($sformatf("starve c%0d ram_addr", c), ram_addr, exp_d ? 32'h84 : 32'h80);
      if (c == 15) check("starve conflict_cnt", 32'(conflict_cnt), 32'd3);
      tick();
    end

    // 4: dbg write 0x40 then read it back, core idle
    core_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'h12345678;
    #3;
    check("dbg wr dbg_gnt", 32'(dbg_gnt), 32'd1);
    check("dbg wr ram_we", 32'(ram_we), 32'd1);
    check("dbg wr ram_wdata", ram_wdata, 32'h12345678);
    tick();
    dbg_we = 1'b0;
    #3;
    check("dbg rd dbg_gnt", 32'(dbg_gnt), 32'd1);
    check("dbg rd ram_we", 32'(ram_we), 32'd0);
    check("dbg rd dbg_rvalid early", 32'(dbg_rvalid), 32'd0);
    tick();
    dbg_req = 1'b0;
    #3;
    check("dbg rd dbg_rvalid", 32'(dbg_rvalid), 32'd1);
    check("dbg rd dbg_rdata", dbg_rdata, 32'h12345678);
    check("dbg rd core_rvalid", 32'(core_rvalid), 32'd0);

    // 5: core read 0x20, then dbg read 0x24 while the core data returns
    tick();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h20;
    #3;
    check("intl core_stall", 32'(core_stall), 32'd0);
    check("intl ram_addr c", ram_addr, 32'h20);
    tick();
    core_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h24;
    #3;
    check("intl core_rvalid", 32'(core_rvalid), 32'd1);
    check("intl core_rdata", core_rdata, 32'hA5A50020);
    check("intl dbg_gnt", 32'(dbg_gnt), 32'd1);
    check("intl ram_addr d", ram_addr, 32'h24);
    check("intl dbg_rvalid early", 32'(dbg_rvalid), 32'd0);
    tick();
    dbg_req = 1'b0;
    #3;
    check("intl dbg_rvalid", 32'(dbg_rvalid), 32'd1);
    check("intl dbg_rdata", dbg_rdata, 32'h5A5A0024);
    check("intl core_rvalid late", 32'(core_rvalid), 32'd0);

    // 6: build up starvation, then reset while a core read is in flight
    tick();
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h80;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h84;
    #3;
    check("mid pre dbg_gnt", 32'(dbg_gnt), 32'd0);
    tick();
    core_we = 1'b0; core_addr = 32'h10;
    #3;
    check("mid rd core_stall", 32'(core_stall), 32'd0);
    #1;
    rst = 1'b0;
    #1;
    check("mid in-rst core_stall", 32'(core_stall), 32'd1);
    check("mid in-rst dbg_gnt", 32'(dbg_gnt), 32'd0);
    check("mid in-rst conflict_cnt", 32'(conflict_cnt), 32'd0);
    tick();
    rst = 1'b1;
    core_req = 1'b0; dbg_req = 1'b0;
    #3;
    check("mid post core_rvalid", 32'(core_rvalid), 32'd0);
    check("mid post dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    tick();
    #3;
    check("mid post+1 core_rvalid", 32'(core_rvalid), 32'd0);
    // With the starvation count cleared, dbg must wait exactly 4 cycles again.
    tick();
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h80;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h84;
    for (int c = 0; c < 5; c++) begin
      #3;
      check($sformatf("mid probe c%0d dbg_gnt", c), 32'(dbg_gnt), 32'(c == 4));
      tick();
    end
    core_req = 1'b0; dbg_req = 1'b0;
    #3;
    check("mid probe conflict_cnt", 32'(conflict_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
